ui_button_event_decoder: RTL and testbench

Consumes the debounced active-low button level produced by the UI trigger-smoothing stage and turns it into single-cycle user-intent events: press, click, double-click, long-press and auto-repeat. It sits between the per-button smoother and the music box control logic (mode select, volume, track skip). All event outputs are active-high, one clock wide, and registered.

---
 rtl/ui_button_event_decoder.sv | 127 ++++++++++++
 tb/tb_ui_button_event_decoder.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/ui_button_event_decoder.sv
// Button event decoder: turns a debounced active-low button level into one-cycle
// press / click / double-click / long-press / auto-repeat events.
module ui_button_event_decoder #(
  parameter int unsigned LONG_CYCLES   = 25_000_000,
  parameter int unsigned REPEAT_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES    = 12_500_000
) (
  input  logic clock_50Mhz,
  input  logic reset_n,
  input  logic buttonWire_n,
  input  logic enable,
  output logic pressPulse,
  output logic clickPulse,
  output logic doubleClickPulse,
  output logic longPressPulse,
  output logic repeatPulse,
  output logic heldLevel
);

  localparam int unsigned MaxLR = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned MaxCycles = (MaxLR > GAP_CYCLES) ? MaxLR : GAP_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCycles);

  localparam logic [CntW-1:0] LongLast   = CntW'(LONG_CYCLES - 1);
  localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StPressed,
    StLongHeld,
    StWaitGap,
    StSecondHeld
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            btn_q, btn_prev;
  logic            press_edge, release_edge;
  logic            press_d, click_d, dbl_d, long_d, repeat_d, held_d;

  assign press_edge   = btn_prev & ~btn_q;
  assign release_edge = ~btn_prev & btn_q;

  // Input stage resets to "pressed" so a button held through reset never yields a press.
  always_ff @(posedge clock_50Mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_q            <= 1'b0;
      btn_prev         <= 1'b0;
      state_q          <= StIdle;
      cnt_q            <= '0;
      pressPulse       <= 1'b0;
      clickPulse       <= 1'b0;
      doubleClickPulse <= 1'b0;
      longPressPulse   <= 1'b0;
      repeatPulse      <= 1'b0;
      heldLevel        <= 1'b0;
    end else begin
      btn_q            <= buttonWire_n;
      btn_prev         <= btn_q;
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      pressPulse       <= press_d;
      clickPulse       <= click_d;
      doubleClickPulse <= dbl_d;
      longPressPulse   <= long_d;
      repeatPulse      <= repeat_d;
      heldLevel        <= held_d;
    end
  end

  // Release beats the long terminal count; press beats the gap terminal count.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    if (enable) begin
      unique case (state_q)
        StIdle: begin
          if (press_edge) state_d = StPressed;
        end
        StPressed: begin
          if (release_edge)           state_d = StWaitGap;
          else if (cnt_q == LongLast) state_d = StLongHeld;
          else                        cnt_d   = cnt_q + 1'b1;
        end
        StLongHeld: begin
          if (release_edge)              state_d = StIdle;
          else if (cnt_q != RepeatLast)  cnt_d   = cnt_q + 1'b1;
        end
        StWaitGap: begin
          if (press_edge)            state_d = StSecondHeld;
          else if (cnt_q == GapLast) state_d = StIdle;
          else                       cnt_d   = cnt_q + 1'b1;
        end
        StSecondHeld: begin
          if (release_edge) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end else begin
      state_d = StIdle;
    end
  end

  always_comb begin
    press_d  = 1'b0;
    click_d  = 1'b0;
    dbl_d    = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    held_d   = (state_d == StPressed) || (state_d == StLongHeld) || (state_d == StSecondHeld);
    if (enable) begin
      unique case (state_q)
        StIdle:     press_d  = press_edge;
        StPressed:  long_d   = ~release_edge && (cnt_q == LongLast);
        StLongHeld: repeat_d = ~release_edge && (cnt_q == RepeatLast);
        StWaitGap: begin
          press_d = press_edge;
          dbl_d   = press_edge;
          click_d = ~press_edge && (cnt_q == GapLast);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ui_button_event_decoder.sv
// Self-checking bench for ui_button_event_decoder; expected event times are derived
// arithmetically from press/release durations.
module tb_ui_button_event_decoder;

  localparam int L = 20;
  localparam int R = 5;
  localparam int G = 8;
  localparam int N = 8192;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_n = 1'b0;
  logic en = 1'b1;
  logic press, click, dbl, lng, rep, held;

  ui_button_event_decoder #(
    .LONG_CYCLES  (L),
    .REPEAT_CYCLES(R),
    .GAP_CYCLES   (G)
  ) dut (
    .clock_50Mhz     (clk),
    .reset_n         (rst_n),
    .buttonWire_n    (btn_n),
    .enable          (en),
    .pressPulse      (press),
    .clickPulse      (click),
    .doubleClickPulse(dbl),
    .longPressPulse  (lng),
    .repeatPulse     (rep),
    .heldLevel       (held)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit second = 1'b0;
  // Expected {press, click, dbl, long, repeat, held} per counted clock edge.
  bit [5:0] exp_v [N];

  function automatic void mark(int t, int pos);
    if (t >= 0 && t < N) exp_v[t][pos] = 1'b1;
  endfunction

  function automatic void mark_held(int from, int to_excl);
    for (int t = from; t < to_excl; t++) mark(t, 0);
  endfunction

  task automatic check(string tag, logic [5:0] obs, logic [5:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic tick(logic lvl, logic e);
    btn_n = lvl;
    en = e;
    @(posedge clk);
    #1;
    cyc++;
    check("events", {press, click, dbl, lng, rep, held}, (cyc < N) ? exp_v[cyc] : 6'b0);
  endtask

  // Press held for h edges, then released for g edges. The press pulse lands two
  // edges after the first low sample; the FSM sees the release h edges later.
  task automatic do_pair(int h, int g);
    int p;
    p = cyc + 2;
    mark(p, 5);
    mark_held(p, p + h);
    if (second) begin
      mark(p, 3);
      second = 1'b0;
    end else if (h > L) begin
      mark(p + L, 2);
      for (int k = 1; L + k * R < h; k++) mark(p + L + k * R, 1);
    end else if (g > G) begin
      mark(p + h + G, 4);
    end else begin
      second = 1'b1;
    end
    repeat (h) tick(1'b0, 1'b1);
    repeat (g) tick(1'b1, 1'b1);
  endtask

  initial begin
    int p;
    // Button held low through reset: no press after release of reset.
    repeat (3) @(posedge clk);
    #1;
    check("reset_values", {press, click, dbl, lng, rep, held}, 6'b0);
    rst_n = 1'b1;
    repeat (50) tick(1'b0, 1'b1);
    repeat (5) tick(1'b1, 1'b1);

    do_pair(5, 12);          // single click
    do_pair(5, 4);           // double click
    do_pair(5, 12);
    do_pair(41, 6);          // long press with four repeats
    do_pair(20, 12);         // release on long terminal cycle: click, no long
    do_pair(21, 12);         // one cycle longer: long press, no repeat
    do_pair(5, 8);           // press on gap terminal cycle: double click wins
    do_pair(3, 12);
    do_pair(5, 9);           // one cycle late: click then fresh press
    do_pair(4, 12);

    // Enable dropped in LONG_HELD and raised again while still held.
    p = cyc + 2;
    mark(p, 5);
    mark(p + L, 2);
    mark_held(p, p + 23);
    repeat (24) tick(1'b0, 1'b1);
    repeat (5) tick(1'b0, 1'b0);
    repeat (10) tick(1'b0, 1'b1);
    repeat (4) tick(1'b1, 1'b1);
    do_pair(5, 12);

    // Reset while held: heldLevel must drop without a clock edge.
    p = cyc + 2;
    mark(p, 5);
    mark_held(p, p + 3);
    repeat (4) tick(1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_async_held", {press, click, dbl, lng, rep, held}, 6'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick(1'b0, 1'b1);
    repeat (4) tick(1'b1, 1'b1);

    // Reset in WAIT_GAP: the pending click is dropped.
    p = cyc + 2;
    mark(p, 5);
    mark_held(p, p + 5);
    repeat (5) tick(1'b0, 1'b1);
    repeat (3) tick(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_async_gap", {press, click, dbl, lng, rep, held}, 6'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (14) tick(1'b1, 1'b1);

    // Randomized press/release durations around every threshold.
    for (int i = 0; i < 40; i++) begin
      int h, g;
      h = int'($urandom_range(45, 1));
      g = (i == 39) ? 12 : int'($urandom_range(14, 1));
      do_pair(h, g);
    end
    repeat (15) tick(1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
